// File: rtl/edge_pkg.sv
// Shared encodings for the multi-channel edge detector.
// Optional input synchronizer is enabled by defining EDGE_SYNC_EN.
package edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } chan_state_e;

  // True when the sampled transition prev -> cur matches the selected mode.
  function automatic logic edge_qual(input logic [1:0] mode,
                                     input logic       cur,
                                     input logic       prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = cur & ~prev;
      MODE_FALL: hit = ~cur & prev;
      MODE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: optional synchronizer (EDGE_SYNC_EN), arming,
// edge qualification, retriggerable pulse FSM, sticky flag and saturating counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic             pulse_o,
  output logic             flag_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PC_W    = $clog2(PULSE_W + 1);
  localparam logic [PC_W-1:0]  PC_LOAD = PC_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic cur;
  logic sample_vld;

`ifdef EDGE_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] vld_q;

  // vld_q tracks how far valid data has propagated through the synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], in_i};
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign cur        = sync_q[1];
  assign sample_vld = vld_q[1];
`else
  assign cur        = in_i;
  assign sample_vld = 1'b1;
`endif

  logic armed_q;
  logic prev_q;
  logic edge_hit;

  // The first valid sample only seeds prev, so a level held across reset is never an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else if (sample_vld) begin
      armed_q <= 1'b1;
      prev_q  <= cur;
    end
  end

  assign edge_hit = armed_q & edge_qual(mode_i, cur, prev_q);

  chan_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pulse_d = pulse_q;
    case (state_q)
      ST_IDLE: begin
        pulse_d = 1'b0;
        if (edge_hit) begin
          state_d = ST_PULSE;
          pulse_d = 1'b1;
          pc_d    = PC_LOAD;
        end
      end
      ST_PULSE: begin
        if (edge_hit) begin
          pulse_d = 1'b1;
          pc_d    = PC_LOAD;
        end else if (pc_q == '0) begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
        end else begin
          pc_d = pc_q - PC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pulse_q <= pulse_d;
    end
  end

  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear coinciding with an edge still records that edge.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (edge_hit) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
    if (clr_i) begin
      cnt_d = edge_hit ? CNT_W'(1) : '0;
    end else if (edge_hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;
  assign flag_o  = flag_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// N_CH-channel edge detector with per-channel mode, pulse, flag and counter.
// Define EDGE_SYNC_EN to add a 2-flop input synchronizer in every channel.
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PULSE_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_i,
  input  logic [2*N_CH-1:0]     mode_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       pulse_o,
  output logic [N_CH-1:0]       flag_o,
  output logic                  any_o,
  output logic [N_CH*CNT_W-1:0] count_o
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    edge_chan #(
      .PULSE_W(PULSE_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_i   (in_i[gi]),
      .mode_i (mode_i[2*gi +: 2]),
      .clr_i  (clr_i[gi]),
      .pulse_o(pulse_o[gi]),
      .flag_o (flag_o[gi]),
      .count_o(count_o[gi*CNT_W +: CNT_W])
    );
  end

  assign any_o = |pulse_o;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised bench for edge_detect_multi against a cycle-count reference model.
// Honors EDGE_SYNC_EN to match the DUT build.
module tb_edge_detect_multi;

  localparam int N_CH    = 4;
  localparam int PULSE_W = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EDGE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [N_CH-1:0]       in_i;
  logic [2*N_CH-1:0]     mode_i;
  logic [N_CH-1:0]       clr_i;
  logic [N_CH-1:0]       pulse_o;
  logic [N_CH-1:0]       flag_o;
  logic                  any_o;
  logic [N_CH*CNT_W-1:0] count_o;

  edge_detect_multi #(
    .N_CH   (N_CH),
    .PULSE_W(PULSE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (in_i),
    .mode_i (mode_i),
    .clr_i  (clr_i),
    .pulse_o(pulse_o),
    .flag_o (flag_o),
    .any_o  (any_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel remembers how many clocks have passed since
  // its last qualified edge; the pulse is high while that age is below PULSE_W.
  logic [N_CH-1:0] inq[$];
  int              edges_since_rst;
  int              m_age  [N_CH];
  bit              m_flag [N_CH];
  int              m_cnt  [N_CH];
  bit              m_prev [N_CH];

  task automatic model_reset();
    inq.delete();
    edges_since_rst = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_age[ch]  = PULSE_W;
      m_flag[ch] = 1'b0;
      m_cnt[ch]  = 0;
      m_prev[ch] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] in_v, input logic [2*N_CH-1:0] md,
                            input logic [N_CH-1:0] clr);
    logic [N_CH-1:0] cur;
    inq.push_back(in_v);
    if (inq.size() > SYNC_LAT + 1) void'(inq.pop_front());
    cur = (inq.size() == SYNC_LAT + 1) ? inq[0] : '0;
    edges_since_rst++;
    for (int ch = 0; ch < N_CH; ch++) begin
      bit c, hit;
      int m;
      c   = cur[ch];
      m   = int'(md[2*ch +: 2]);
      hit = 1'b0;
      if (edges_since_rst > SYNC_LAT + 1) begin
        if (m == 1) hit = c && !m_prev[ch];
        if (m == 2) hit = !c && m_prev[ch];
        if (m == 3) hit = c != m_prev[ch];
      end
      m_prev[ch] = c;
      if (hit) m_age[ch] = 0;
      else if (m_age[ch] < PULSE_W) m_age[ch]++;
      if (hit) m_flag[ch] = 1'b1;
      else if (clr[ch]) m_flag[ch] = 1'b0;
      if (clr[ch]) m_cnt[ch] = hit ? 1 : 0;
      else if (hit && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [N_CH-1:0]       exp_pulse, exp_flag;
    logic [N_CH*CNT_W-1:0] exp_cnt;
    for (int ch = 0; ch < N_CH; ch++) begin
      exp_pulse[ch]                = (m_age[ch] < PULSE_W);
      exp_flag[ch]                 = m_flag[ch];
      exp_cnt[ch*CNT_W +: CNT_W]   = CNT_W'(m_cnt[ch]);
    end
    check({tag, ".pulse"}, 64'(pulse_o), 64'(exp_pulse));
    check({tag, ".flag"},  64'(flag_o),  64'(exp_flag));
    check({tag, ".any"},   64'(any_o),   64'(|exp_pulse));
    check({tag, ".count"}, 64'(count_o), 64'(exp_cnt));
  endtask

  // Called just after a falling edge: drive, clock once, check on the next falling edge.
  task automatic cycle(input string tag, input logic [N_CH-1:0] in_v,
                       input logic [2*N_CH-1:0] md, input logic [N_CH-1:0] clr);
    in_i   = in_v;
    mode_i = md;
    clr_i  = clr;
    @(posedge clk);
    model_edge(in_v, md, clr);
    @(negedge clk);
    $display("%s t=%0t in=%b mode=%b clr=%b pulse=%b flag=%b any=%b cnt=%h",
             tag, $time, in_v, md, clr, pulse_o, flag_o, any_o, count_o);
    compare_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pulse"}, 64'(pulse_o), 64'(0));
    check({tag, ".flag"},  64'(flag_o),  64'(0));
    check({tag, ".any"},   64'(any_o),   64'(0));
    check({tag, ".count"}, 64'(count_o), 64'(0));
  endtask

  task automatic random_run(input string tag, input int n);
    logic [N_CH-1:0]   in_v;
    logic [2*N_CH-1:0] md;
    logic [N_CH-1:0]   clr;
    in_v = in_i;
    md   = mode_i;
    for (int k = 0; k < n; k++) begin
      in_v = in_v ^ N_CH'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) md = (2*N_CH)'($urandom);
      clr = '0;
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, 15) == 0) clr[ch] = 1'b1;
      cycle(tag, in_v, md, clr);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    in_i   = 4'b1111;
    mode_i = 8'hFF;
    clr_i  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Release with all inputs high and BOTH mode: nothing may fire.
    rst_n = 1'b1;
    repeat (5) cycle("release", 4'b1111, 8'hFF, 4'b0000);

    // Ch0 RISE: falling transition is ignored, rising one pulses.
    cycle("ch0_rise", 4'b1110, 8'b00_00_00_01, 4'b0000);
    cycle("ch0_rise", 4'b1111, 8'b00_00_00_01, 4'b0000);
    repeat (4) cycle("ch0_rise", 4'b1111, 8'b00_00_00_01, 4'b0000);
    cycle("ch0_rise", 4'b1110, 8'b00_00_00_01, 4'b0000);
    repeat (2) cycle("ch0_rise", 4'b1110, 8'b00_00_00_01, 4'b0000);

    // Ch1 BOTH, edges two cycles apart keep the pulse high continuously.
    for (int e = 0; e < 4; e++) begin
      cycle("ch1_both", (e % 2 == 0) ? 4'b0000 : 4'b0010, 8'b00_00_11_00, 4'b0000);
      cycle("ch1_both", (e % 2 == 0) ? 4'b0000 : 4'b0010, 8'b00_00_11_00, 4'b0000);
    end
    repeat (5) cycle("ch1_both", 4'b0010, 8'b00_00_11_00, 4'b0000);

    // Ch2 RISE saturation, then clear coinciding with an edge.
    for (int e = 0; e < 5; e++) begin
      cycle("ch2_sat", 4'b0000, 8'b00_01_00_00, 4'b0000);
      cycle("ch2_sat", 4'b0100, 8'b00_01_00_00, 4'b0000);
    end
    cycle("ch2_clr", 4'b0000, 8'b00_01_00_00, 4'b0000);
    cycle("ch2_clr", 4'b0100, 8'b00_01_00_00, 4'b0100);
    repeat (2 + SYNC_LAT) cycle("ch2_clr", 4'b0100, 8'b00_01_00_00, 4'b0100);

    // Ch3 OFF while toggling, then FALL.
    for (int e = 0; e < 6; e++)
      cycle("ch3_off", (e % 2 == 0) ? 4'b1000 : 4'b0000, 8'b00_00_00_00, 4'b0000);
    cycle("ch3_fall", 4'b1000, 8'b10_00_00_00, 4'b0000);
    repeat (SYNC_LAT + 1) cycle("ch3_fall", 4'b1000, 8'b10_00_00_00, 4'b0000);
    repeat (4 + SYNC_LAT) cycle("ch3_fall", 4'b0000, 8'b10_00_00_00, 4'b0000);

    random_run("rand1", 600);

    // Asynchronous reset mid-pulse, input held high across release.
    cycle("midrst", 4'b0000, 8'hFF, 4'b0000);
    repeat (SYNC_LAT) cycle("midrst", 4'b1111, 8'hFF, 4'b0000);
    cycle("midrst", 4'b1111, 8'hFF, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle("rearm", 4'b1111, 8'hFF, 4'b0000);
    cycle("rearm", 4'b1010, 8'hFF, 4'b0000);
    repeat (4) cycle("rearm", 4'b1010, 8'hFF, 4'b0000);

    random_run("rand2", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Multi-channel, parametrised edge detector with a per-channel edge-mode select (rise/fall/both/off).
- Each detected edge produces a pulse of programmable width; an edge during a pulse retriggers it.
- Each channel also keeps a sticky flag and a saturating event counter.
- Sits between raw control/status inputs and the interrupt/event logic; it succeeds the single-channel toggle-pulse FSM.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- PULSE_W, 1, output pulse width in clk cycles (>=1)
- CNT_W, 8, width of each per-channel saturating event counter (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_i  input  N_CH  monitored inputs, bit i = channel i
- mode_i  input  2*N_CH  per-channel mode, bits [2i+1:2i]
- clr_i  input  N_CH  per-channel clear of flag and counter (level, sampled each clk)
- pulse_o  output  N_CH  per-channel event pulse
- flag_o  output  N_CH  per-channel sticky "edge seen"
- any_o  output  1  OR of pulse_o
- count_o  output  N_CH*CNT_W  per-channel event counters, channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low, async): pulse_o=0, flag_o=0, count_o=0, any_o=0, all channels in IDLE, prev=0, armed=0.
- Arming: on the first clk edge after rst_n deasserts, each channel loads prev<=in (or the synchronized in) with no edge detection and sets armed=1.
  - A high input at reset release therefore never produces a spurious edge.
- Edge qualification (armed only), with cur = sampled input:
  - mode 00 OFF: never.
  - mode 01 RISE: cur & ~prev.
  - mode 10 FALL: ~cur & prev.
  - mode 11 BOTH: cur ^ prev.
  - mode_i is sampled every cycle; there is no latching.
- Latency: pulse_o rises at the first clk edge where the qualified edge condition holds. That is 1 clk after the input change is sampled.
- Per-channel FSM, with pulse counter pc of width $clog2(PULSE_W+1):
  - IDLE: pulse_o=0. On edge -> PULSE, pulse_o<=1, pc<=PULSE_W-1.
  - PULSE: on edge (retrigger) -> stay, pc<=PULSE_W-1, pulse_o stays 1. Else if pc==0 -> IDLE, pulse_o<=0. Else pc<=pc-1.
  - Result: an isolated edge gives exactly PULSE_W high cycles. Back-to-back edges keep pulse_o high continuously until PULSE_W cycles after the last edge.
  - Unreachable state -> IDLE, pulse_o=0.
- Mode change to OFF mid-pulse: the running pulse completes normally; no new triggers occur.
- flag_o[i]: set on a qualified edge, cleared when clr_i[i]=1. If set and clear occur in the same cycle, set wins (flag=1).
- count_o[i]: increments by 1 per qualified edge and saturates at 2^CNT_W-1. clr_i[i] clears it to 0. If clear and an edge occur in the same cycle, the counter loads 1.
- any_o: combinational OR of the registered pulse_o.
- Reset mid-pulse: all state clears immediately and the channel must re-arm.

Optional Feature:
- Macro EDGE_SYNC_EN.
- Defined: a 2-flop synchronizer per channel sits in front of prev/cur. It resets to 0, adds 2 clk of latency (total 3 from the asynchronous input change), and arming occurs on the first edge after the synchronizer output is valid (third clk after reset release).
- Undefined: in_i is used directly and must be synchronous to clk; latency is 1 clk.

Decomposition:
- Package edge_pkg:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - channel state encoding ST_IDLE, ST_PULSE
- Sub-module edge_chan: one channel containing the sync, arm, prev, FSM, flag and counter.
- edge_detect_multi: generate-instantiates N_CH copies and builds any_o.

Test Plan:
- Reset release with in_i=4'b1111, mode BOTH on all channels -> no pulse, flag_o=0 and count_o=0 for 5 cycles.
- Ch0 RISE, PULSE_W=1: in_i[0] 0->1 -> pulse_o[0]=1 for exactly 1 cycle, 1 clk after sampling; count_o[7:0]=1. The 1->0 transition produces no pulse.
- PULSE_W=3, ch1 BOTH, edges 2 cycles apart -> pulse_o[1] high continuously, ending 3 cycles after the last edge; count=number of edges.
- CNT_W=2, ch2 RISE, 5 rising edges -> count_o saturates at 3. Then assert clr_i[2] in the same cycle as an edge -> count=1 and flag stays 1.
- Ch3 mode OFF with toggling input -> no pulse, flag or count. Switching to FALL mid-sequence -> the next 1->0 transition pulses.
- Assert rst_n low mid-pulse -> all outputs 0 asynchronously. After release, the held input level causes no pulse. With EDGE_SYNC_EN defined, repeat the scenario 2 case and check 3 clk latency.
